me_sched: RTL

ME_SCHED -- requirements
Module: me_sched

---
 rtl/me_sched_if.sv | 36 +++
 rtl/me_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/me_sched_if.sv
// Requester/engine bundle for the modular-exponentiation job scheduler.
// The scheduler uses the slave view; requesters and the engine use the master view.
interface me_sched_if #(
  parameter int M_SIZE = 3072,
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 4
);
  logic [N_REQ-1:0]        req;
  logic [2*N_REQ-1:0]      op;
  logic [N_REQ*M_SIZE-1:0] a_in;
  logic [N_REQ*M_SIZE-1:0] e_in;
  logic [N_REQ-1:0]        gnt;
  logic                    en_one_mm;
  logic                    en_pre_me;
  logic                    en_me;
  logic [TAG_W-1:0]        num;
  logic [M_SIZE-1:0]       a;
  logic [M_SIZE-1:0]       e;
  logic [M_SIZE-1:0]       z;
  logic [TAG_W-1:0]        num_out;
  logic                    done;
  logic [N_REQ-1:0]        rsp_valid;
  logic [M_SIZE-1:0]       rsp_z;
  logic                    busy;
  logic                    err;

  modport slave (
    input  req, op, a_in, e_in, z, num_out, done,
    output gnt, en_one_mm, en_pre_me, en_me, num, a, e, rsp_valid, rsp_z, busy, err
  );

  modport master (
    output req, op, a_in, e_in, z, num_out, done,
    input  gnt, en_one_mm, en_pre_me, en_me, num, a, e, rsp_valid, rsp_z, busy, err
  );
endinterface

// File: rtl/me_sched.sv
// Round-robin scheduler that issues one job at a time to the modular-exponentiation
// engine, matches the tagged completion and returns the result to the requester.
module me_sched #(
  parameter int M_SIZE  = 3072,
  parameter int N_REQ   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16384
) (
  input logic       clk,
  input logic       rst_n,
  me_sched_if.slave bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_rrPtr;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_cand;
  logic              w_anyReq;
  logic [1:0]        r_op;
  logic [1:0]        r_seq;
  logic [TAG_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_cnt;
  logic [M_SIZE-1:0] r_a;
  logic [M_SIZE-1:0] r_e;
  logic [M_SIZE-1:0] r_rspZ;
  logic              w_tagMatch;
  logic              w_timeout;

  assign w_tagMatch = (bus.num_out == r_num);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign bus.num    = r_num;
  assign bus.a      = r_a;
  assign bus.e      = r_e;
  assign bus.rsp_z  = r_rspZ;

  // Scan downward from the farthest offset so the requester nearest rr wins.
  always_comb begin
    w_anyReq = 1'b0;
    w_winner = r_rrPtr;
    w_cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = r_rrPtr + ID_W'(k);
      if (bus.req[w_cand]) begin
        w_anyReq = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    bus.gnt       = '0;
    bus.en_one_mm = 1'b0;
    bus.en_pre_me = 1'b0;
    bus.en_me     = 1'b0;
    bus.rsp_valid = '0;
    bus.err       = 1'b0;
    bus.busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_anyReq) w_nextState = ISSUE;
      end
      ISSUE: begin
        bus.gnt[r_id] = 1'b1;
        case (r_op)
          2'd0:    bus.en_one_mm = 1'b1;
          2'd1:    bus.en_pre_me = 1'b1;
          2'd2:    bus.en_me     = 1'b1;
          default: bus.err       = 1'b1;
        endcase
        w_nextState = (r_op == 2'd3) ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.done && w_tagMatch) begin
          w_nextState = RESP;
        end else begin
          if (bus.done) bus.err = 1'b1;
          if (w_timeout) begin
            bus.err     = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      RESP: begin
        bus.rsp_valid[r_id] = 1'b1;
        w_nextState         = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A matching completion takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_rrPtr <= '0;
      r_op    <= '0;
      r_seq   <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_e     <= '0;
      r_rspZ  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_id  <= w_winner;
            r_op  <= bus.op[2*w_winner +: 2];
            r_a   <= bus.a_in[w_winner*M_SIZE +: M_SIZE];
            r_e   <= bus.e_in[w_winner*M_SIZE +: M_SIZE];
            r_num <= TAG_W'({r_seq, w_winner});
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          if (r_op == 2'd3) r_rrPtr <= r_id + 1'b1;
        end
        WAIT: begin
          if (bus.done && w_tagMatch) r_rspZ  <= bus.z;
          else if (w_timeout)         r_rrPtr <= r_id + 1'b1;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        RESP: begin
          r_seq   <= r_seq + 1'b1;
          r_rrPtr <= r_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
